// File: rtl/ght_checkpoint_queue.sv
// Speculative global-history register with an in-order checkpoint queue.
// Pops train the PHT; a mispredicting pop restores history and flushes younger entries.
module ght_checkpoint_queue #(
    parameter int GHT_BIT    = 4,
    parameter int PHT_PC_BIT = 2,
    parameter int DEPTH      = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    input  logic [31:0]                  pred_pc,
    output logic                         pred_ready,
    output logic [GHT_BIT-1:0]           spec_ght,
    input  logic                         res_valid,
    input  logic                         res_taken,
    output logic                         res_ready,
    output logic                         upd_valid,
    output logic                         upd_taken,
    output logic [GHT_BIT-1:0]           upd_ght,
    output logic [PHT_PC_BIT-1:0]        upd_pc_idx,
    output logic                         mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [GHT_BIT-1:0]    snap_mem [DEPTH];
    logic                  bit_mem  [DEPTH];
    logic [PHT_PC_BIT-1:0] idx_mem  [DEPTH];

    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [GHT_BIT-1:0]    spec_q, spec_d;

    logic                  upd_valid_q, upd_taken_q, mis_q;
    logic [GHT_BIT-1:0]    upd_ght_q;
    logic [PHT_PC_BIT-1:0] upd_idx_q;

    logic                  push, pop, mis, wr_en;
    logic [GHT_BIT-1:0]    head_snap;
    logic                  head_bit;
    logic [PHT_PC_BIT-1:0] head_idx;

    // Handshakes depend only on registered occupancy.
    assign pred_ready = (count_q < CW'(DEPTH));
    assign res_ready  = (count_q != '0);

    assign head_snap = snap_mem[head_q];
    assign head_bit  = bit_mem[head_q];
    assign head_idx  = idx_mem[head_q];

    always_comb begin
        push    = pred_valid && pred_ready;
        pop     = res_valid && res_ready;
        mis     = pop && (res_taken != head_bit);
        wr_en   = 1'b0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        spec_d  = spec_q;
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (mis) begin
            // Fetch is being redirected, so a same-cycle push is dropped.
            spec_d  = {head_snap[GHT_BIT-2:0], res_taken};
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) begin
                wr_en  = 1'b1;
                tail_d = tail_q + PW'(1);
                spec_d = {spec_q[GHT_BIT-2:0], pred_taken};
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            snap_mem[tail_q] <= spec_q;
            bit_mem[tail_q]  <= pred_taken;
            idx_mem[tail_q]  <= pred_pc[PHT_PC_BIT+1:2];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            spec_q      <= '0;
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_ght_q   <= '0;
            upd_idx_q   <= '0;
            mis_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            spec_q      <= spec_d;
            upd_valid_q <= pop;
            mis_q       <= mis;
            if (pop) begin
                upd_taken_q <= res_taken;
                upd_ght_q   <= head_snap;
                upd_idx_q   <= head_idx;
            end
        end
    end

    assign spec_ght   = spec_q;
    assign count      = count_q;
    assign upd_valid  = upd_valid_q;
    assign upd_taken  = upd_taken_q;
    assign upd_ght    = upd_ght_q;
    assign upd_pc_idx = upd_idx_q;
    assign mispredict = mis_q;

endmodule

// File: doc/ght_checkpoint_queue.md
Name: ght_checkpoint_queue

Overview:
- Speculative global-history manager for the GAs predictor: the resolve/recover side that pairs with the prediction side.
- At fetch, each predicted branch shifts its predicted direction into a speculative GHT.
- Each predicted branch also pushes a checkpoint: pre-shift history, predicted bit and PC index.
- At in-order resolution, the oldest checkpoint is popped and drives the PHT training port; a mispredict restores history from the checkpoint and flushes all younger entries.

Parameters:
- GHT_BIT, 4: global history width.
- PHT_PC_BIT, 2: PC bits used for the PHT index, taken from pc[PHT_PC_BIT+1:2].
- DEPTH, 8: checkpoint entries; must be a power of 2 and at least 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pred_valid  in  1  predicted branch presented at fetch.
- pred_taken  in  1  predicted direction: 1 taken, 0 not taken.
- pred_pc  in  32  PC of the predicted branch.
- pred_ready  out  1  queue can accept a push; equals (count < DEPTH).
- spec_ght  out  GHT_BIT  speculative history; the predictor indexes with this.
- res_valid  in  1  oldest outstanding branch resolved this cycle.
- res_taken  in  1  actual branch outcome.
- res_ready  out  1  queue holds at least one entry; equals (count != 0).
- upd_valid  out  1  registered PHT-training strobe.
- upd_taken  out  1  actual outcome to write into the PHT.
- upd_ght  out  GHT_BIT  history the branch was predicted with; the PHT row.
- upd_pc_idx  out  PHT_PC_BIT  PHT column.
- mispredict  out  1  registered; high one cycle when the popped prediction was wrong.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, immediate): spec_ght=0, count=0, head=tail=0, upd_valid=0, upd_taken=0, upd_ght=0, upd_pc_idx=0, mispredict=0. Entry storage does not need a reset.
- Entry format: {snap_ght, pred_bit, pc_idx}.
- Push (pred_valid && pred_ready):
  - writes {spec_ght, pred_taken, pred_pc[PHT_PC_BIT+1:2]} at tail; tail = (tail+1) mod DEPTH.
  - next cycle, spec_ght = {spec_ght[GHT_BIT-2:0], pred_taken}.
- pred_valid while full: ignored; spec_ght and the queue are unchanged.
- Pop (res_valid && res_ready): reads the entry at head; head advances.
  - Next cycle: upd_valid=1, upd_taken=res_taken, upd_ght=snap_ght, upd_pc_idx=pc_idx.
  - Next cycle: mispredict = (res_taken != pred_bit).
- res_valid while empty: ignored; upd_valid=0 next cycle.
- upd_valid and mispredict deassert on the cycle after any cycle with no pop.
- Correct pop with no push: count decrements; spec_ght unchanged.
- Correct pop with simultaneous push: count unchanged; spec_ght shifts in pred_taken.
- Mispredicting pop:
  - next spec_ght = {snap_ght[GHT_BIT-2:0], res_taken}.
  - head=tail, count=0; all younger entries are discarded.
  - A push in the same cycle is discarded and has no effect on spec_ght or the queue, because fetch is being redirected.
- pred_ready and res_ready depend only on the registered count; they have no combinational path from pred_* or res_*.
- With a full queue and a simultaneous pop, pred_ready is still 0 that cycle, so no push is accepted.
- Pointers wrap modulo DEPTH. count is kept explicitly, so full and empty are unambiguous.
- Latency: spec_ght is valid 1 cycle after a push; training outputs are valid 1 cycle after a pop.
- Throughput: 1 push and 1 pop per cycle.

Test Plan:
1. Reset, then push T, T, N, T on consecutive cycles.
   - spec_ght goes 0000 -> 0001 -> 0011 -> 0110 -> 1101; count=4.
2. Continuing from test 1, resolve T, T, N, T in order.
   - upd_ght sequence 0000, 0001, 0011, 0110, each with upd_valid=1 and mispredict=0.
   - End state: spec_ght=1101, count=0.
3. From reset, push T (pc 0x8), N, T; then resolve with res_taken=0.
   - Next cycle: mispredict=1, upd_ght=0000, upd_taken=0, upd_pc_idx=2, spec_ght=0000, count=0.
   - A push issued on the resolving cycle is dropped.
4. DEPTH=8: push 8 taken branches.
   - pred_ready=0, spec_ght=1111; a 9th push is ignored and count stays 8.
   - Pop one correct: pred_ready=1 and the next push is accepted.
5. With count=3, push T and pop correct in the same cycle.
   - count=3; spec_ght shifts in 1.
6. Back-to-back edge cases.
   - res_valid with count=0: upd_valid stays 0.
   - With count=5, assert reset between clock edges: count, spec_ght, upd_valid and mispredict go to 0 before the next edge.
